keypad_ascii_fifo: RTL and testbench

Parametrised keypad front end that turns debounced key codes into ASCII characters and buffers them for a byte-stream consumer such as the UART/SPI transmitter. It detects each new key press, applies a lockout against repeated triggers, maps the 4-bit key code to ASCII in decimal or hex mode, and queues the result in a first-word-fall-through FIFO. The output is a valid/ready stream with occupancy and overflow status. It replaces the combinational key-to-ASCII decode plus `start` strobe.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 45 ++++
 rtl/keypad_ascii_fifo.sv | 109 ++++++++++
 tb/tb_keypad_ascii_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, lockout state type and key-code to ASCII mapping for the keypad front end.
package keypad_pkg;

    localparam logic [7:0] KEY_STAR = 8'h2A;
    localparam logic [7:0] KEY_HASH = 8'h23;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic {IDLE, LOCKOUT} lock_state_t;

    // Hex B maps to 'B' here; the top level filters out the idle code before enqueueing.
    function automatic logic [7:0] key2ascii(input logic [3:0] code, input logic hex_mode,
                                             output logic valid);
        logic [7:0] ch;
        ch    = 8'h00;
        valid = 1'b0;
        if (code <= 4'd9) begin
            ch    = ASCII_0 + {4'h0, code};
            valid = 1'b1;
        end else if (hex_mode) begin
            ch    = ASCII_A + {4'h0, code - 4'd10};
            valid = 1'b1;
        end else if (code == 4'hA) begin
            ch    = KEY_STAR;
            valid = 1'b1;
        end else if (code == 4'hC) begin
            ch    = KEY_HASH;
            valid = 1'b1;
        end
        return ch;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rd_en   = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/keypad_ascii_fifo.sv
// Keypad front end: press detection, repeat lockout, ASCII mapping and a buffered byte stream.
module keypad_ascii_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter bit          HEX_MODE  = 1'b0,
    parameter logic [3:0]  IDLE_CODE = 4'd11,
    parameter int unsigned HOLDOFF   = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 num,
    input  logic                       PB_state,
    input  logic                       clear_ovf,
    output logic [7:0]                 data,
    output logic                       valid,
    input  logic                       ready,
    output logic [7:0]                 LED,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       drop,
    output logic                       overflow
);

    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF - 1);

    lock_state_t   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pb_q;
    logic [7:0]    led_q;
    logic          drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    key_char;
    logic          key_mapped;
    logic          press, push, pop, ovf_set;

    always_comb begin
        key_char = key2ascii(num, HEX_MODE, key_mapped);
        press    = PB_state && !pb_q && (num != IDLE_CODE);
        pop      = valid && ready;
        state_d  = state_q;
        hold_d   = hold_q;
        push     = 1'b0;
        drop_d   = 1'b0;
        ovf_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = LOCKOUT;
                    hold_d  = HOLD_INIT;
                    if (key_mapped && (!full || pop)) begin
                        push = 1'b1;
                    end else begin
                        drop_d  = 1'b1;
                        ovf_set = key_mapped;
                    end
                end
            end
            LOCKOUT: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ovf_d = clear_ovf ? 1'b0 : (ovf_q || ovf_set);
    end

    // pb_q resets high so a key held across reset is not seen as a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            pb_q    <= 1'b1;
            led_q   <= 8'h00;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pb_q    <= PB_state;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            if (push) led_q <= key_char;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (key_char),
        .pop_i   (pop),
        .rdata_o (data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign valid    = !empty;
    assign LED      = led_q;
    assign drop     = drop_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_ascii_fifo.sv
// Directed bench: a decimal and a hex instance share stimulus; DEPTH=4, HOLDOFF=4.
module tb_keypad_ascii_fifo;

    logic       clk = 1'b0;
    logic       reset, PB_state, clear_ovf, ready;
    logic [3:0] num;

    logic [7:0] d_data, d_led, h_data, h_led;
    logic [2:0] d_count, h_count;
    logic       d_valid, d_full, d_empty, d_drop, d_ovf;
    logic       h_valid, h_full, h_empty, h_drop, h_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keypad_ascii_fifo #(.DEPTH(4), .HEX_MODE(1'b0), .IDLE_CODE(4'd11), .HOLDOFF(4)) dut_dec (
        .clk(clk), .reset(reset), .num(num), .PB_state(PB_state), .clear_ovf(clear_ovf),
        .data(d_data), .valid(d_valid), .ready(ready), .LED(d_led), .count(d_count),
        .full(d_full), .empty(d_empty), .drop(d_drop), .overflow(d_ovf)
    );

    keypad_ascii_fifo #(.DEPTH(4), .HEX_MODE(1'b1), .IDLE_CODE(4'd11), .HOLDOFF(4)) dut_hex (
        .clk(clk), .reset(reset), .num(num), .PB_state(PB_state), .clear_ovf(clear_ovf),
        .data(h_data), .valid(h_valid), .ready(ready), .LED(h_led), .count(h_count),
        .full(h_full), .empty(h_empty), .drop(h_drop), .overflow(h_ovf)
    );

    typedef struct {
        logic [3:0] code;
        logic       d_ok;
        logic [7:0] d_ch;
        logic       h_ok;
        logic [7:0] h_ch;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] drain [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns in the cycle after the press, where its effects are visible.
    task automatic press(input logic [3:0] code);
        tick();
        num      = code;
        PB_state = 1'b1;
        tick();
        PB_state = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d_led_exp, h_led_exp;
        logic       exp_drop_d, exp_drop_h;

        vecs[0] = '{4'h5, 1'b1, 8'h35, 1'b1, 8'h35};
        vecs[1] = '{4'h0, 1'b1, 8'h30, 1'b1, 8'h30};
        vecs[2] = '{4'h9, 1'b1, 8'h39, 1'b1, 8'h39};
        vecs[3] = '{4'hA, 1'b1, 8'h2A, 1'b1, 8'h41};
        vecs[4] = '{4'hC, 1'b1, 8'h23, 1'b1, 8'h43};
        vecs[5] = '{4'hE, 1'b0, 8'h00, 1'b1, 8'h45};
        vecs[6] = '{4'hF, 1'b0, 8'h00, 1'b1, 8'h46};
        vecs[7] = '{4'hD, 1'b0, 8'h00, 1'b1, 8'h44};
        vecs[8] = '{4'hB, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[9] = '{4'h7, 1'b1, 8'h37, 1'b1, 8'h37};

        reset = 1'b1; PB_state = 1'b0; clear_ovf = 1'b0; ready = 1'b0; num = 4'hB;
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst_count", d_count, 0);
        check("rst_empty", d_empty, 1);
        check("rst_full", d_full, 0);
        check("rst_valid", d_valid, 0);
        check("rst_data", d_data, 8'h00);
        check("rst_led", d_led, 8'h00);
        check("rst_drop", d_drop, 0);
        check("rst_ovf", d_ovf, 0);
        check("rst_hex_valid", h_valid, 0);

        // Single presses into an empty FIFO, each popped before the next.
        d_led_exp = 8'h00;
        h_led_exp = 8'h00;
        for (int i = 0; i < 10; i++) begin
            press(vecs[i].code);
            exp_drop_d = (vecs[i].code != 4'hB) && !vecs[i].d_ok;
            exp_drop_h = (vecs[i].code != 4'hB) && !vecs[i].h_ok;
            if (vecs[i].d_ok) d_led_exp = vecs[i].d_ch;
            if (vecs[i].h_ok) h_led_exp = vecs[i].h_ch;
            check($sformatf("vec%0d_d_valid", i), d_valid, vecs[i].d_ok);
            check($sformatf("vec%0d_d_data", i), d_data, vecs[i].d_ch);
            check($sformatf("vec%0d_d_count", i), d_count, vecs[i].d_ok);
            check($sformatf("vec%0d_d_led", i), d_led, d_led_exp);
            check($sformatf("vec%0d_d_drop", i), d_drop, exp_drop_d);
            check($sformatf("vec%0d_d_ovf", i), d_ovf, 0);
            check($sformatf("vec%0d_h_valid", i), h_valid, vecs[i].h_ok);
            check($sformatf("vec%0d_h_data", i), h_data, vecs[i].h_ch);
            check($sformatf("vec%0d_h_led", i), h_led, h_led_exp);
            check($sformatf("vec%0d_h_drop", i), h_drop, exp_drop_h);
            ready = 1'b1;
            tick();
            ready = 1'b0;
            check($sformatf("vec%0d_drop_end", i), d_drop, 0);
            check($sformatf("vec%0d_popped", i), d_valid, 0);
            repeat (3) tick();
        end

        // Lockout: press at +0 accepted, +2 ignored silently, +5 accepted.
        press(4'h3);
        check("lk_drop0", d_drop, 0);
        tick();
        num = 4'h7; PB_state = 1'b1;
        tick();
        PB_state = 1'b0;
        tick();
        check("lk_drop2", d_drop, 0);
        tick();
        num = 4'h8; PB_state = 1'b1;
        tick();
        PB_state = 1'b0;
        check("lk_count", d_count, 2);
        check("lk_drop5", d_drop, 0);
        check("lk_head0", d_data, 8'h33);
        ready = 1'b1;
        tick();
        check("lk_head1", d_data, 8'h38);
        check("lk_count1", d_count, 1);
        tick();
        ready = 1'b0;
        check("lk_drained", d_valid, 0);
        repeat (3) tick();

        // Fill DEPTH=4, then overflow.
        for (int k = 1; k <= 4; k++) begin
            press(4'(k));
            repeat (3) tick();
        end
        check("fill_full", d_full, 1);
        check("fill_count", d_count, 4);
        check("fill_ovf0", d_ovf, 0);
        press(4'h5);
        check("ovf_drop", d_drop, 1);
        check("ovf_flag", d_ovf, 1);
        check("ovf_count", d_count, 4);
        check("ovf_led", d_led, 8'h34);
        tick();
        check("ovf_drop_end", d_drop, 0);
        check("ovf_sticky", d_ovf, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", d_ovf, 0);
        repeat (3) tick();

        // Clear wins over a same-cycle overflow set.
        tick();
        num = 4'h6; PB_state = 1'b1; clear_ovf = 1'b1;
        tick();
        PB_state = 1'b0; clear_ovf = 1'b0;
        check("clrwin_drop", d_drop, 1);
        check("clrwin_ovf", d_ovf, 0);
        tick();
        check("clrwin_ovf_after", d_ovf, 0);
        repeat (3) tick();

        // Full FIFO, press and pop together; order across pointer wrap.
        tick();
        num = 4'h7; PB_state = 1'b1; ready = 1'b1;
        tick();
        PB_state = 1'b0;
        check("fpp_count", d_count, 4);
        check("fpp_full", d_full, 1);
        check("fpp_drop", d_drop, 0);
        check("fpp_led", d_led, 8'h37);
        drain[0] = 8'h32; drain[1] = 8'h33; drain[2] = 8'h34; drain[3] = 8'h37;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), d_data, drain[i]);
            tick();
        end
        ready = 1'b0;
        check("drain_valid", d_valid, 0);
        check("drain_empty", d_empty, 1);
        check("drain_data", d_data, 8'h00);
        repeat (3) tick();

        // Key held through reset deassertion yields no byte.
        PB_state = 1'b1; num = 4'h4; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        check("hold_count", d_count, 0);
        check("hold_valid", d_valid, 0);
        check("hold_drop", d_drop, 0);
        PB_state = 1'b0;
        tick();

        // Reset with 3 queued and a lockout running.
        press(4'h1);
        repeat (3) tick();
        press(4'h2);
        repeat (3) tick();
        press(4'h3);
        check("q3_count", d_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstq_count", d_count, 0);
        check("rstq_valid", d_valid, 0);
        press(4'h9);
        check("rstq_press_count", d_count, 1);
        check("rstq_press_data", d_data, 8'h39);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
